smoldvi_timing_ctrl: RTL and testbench



---
 rtl/smoldvi_timing_pkg.sv | 40 ++++
 rtl/smoldvi_timing_axis.sv | 50 +++++
 rtl/smoldvi_timing_ctrl.sv | 123 ++++++++++++
 tb/tb_smoldvi_timing_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/smoldvi_timing_pkg.sv
// smoldvi timing: shared constants (640x480@60 defaults, sync polarities,
// pixel width), FSM state type and the registered output bundle.
package smoldvi_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam int unsigned DEF_W_CNT    = 12;

   // 0 = sync pulse is driven low
   localparam logic DEF_H_SYNC_POL = 1'b0;
   localparam logic DEF_V_SYNC_POL = 1'b0;

   localparam int unsigned PIX_W = 24;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Everything the TMDS encoders see, registered together so it stays aligned
   typedef struct packed {
      logic             den;
      logic             hsync;
      logic             vsync;
      logic             frame_start;
      logic [PIX_W-1:0] rgb;
   } tmds_out_t;

   // Drive the sync line to its asserted level inside the window
   function automatic logic sync_level(input logic in_win, input logic pol);
      return in_win ? pol : ~pol;
   endfunction

endpackage

// File: rtl/smoldvi_timing_axis.sv
// One raster axis: wrapping position counter plus active/sync window decode.
// Used once for pixels within a line and once for lines within a frame.
module smoldvi_timing_axis
   import smoldvi_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP,
   parameter int unsigned W_CNT  = DEF_W_CNT
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_adv,
   output logic [W_CNT-1:0] o_cnt,
   output logic             o_last,
   output logic             o_active,
   output logic             o_sync
);

   localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

   // The counter must be able to reach TOTAL-1
   if (TOTAL > (2 ** W_CNT)) begin : g_bad_width
      $error("smoldvi_timing_axis: ACTIVE+FP+SYNC+BP exceeds 2**W_CNT");
   end

   localparam logic [W_CNT-1:0] LAST      = W_CNT'(TOTAL - 1);
   localparam logic [W_CNT:0]   L_ACTIVE  = (W_CNT+1)'(ACTIVE);
   localparam logic [W_CNT:0]   L_SYNC_LO = (W_CNT+1)'(ACTIVE + FP);
   localparam logic [W_CNT:0]   L_SYNC_HI = (W_CNT+1)'(ACTIVE + FP + SYNC);

   logic [W_CNT-1:0] r_cnt;
   logic [W_CNT:0]   w_cnt_x;

   assign w_cnt_x  = {1'b0, r_cnt};
   assign o_cnt    = r_cnt;
   assign o_last   = (r_cnt == LAST);
   assign o_active = (w_cnt_x < L_ACTIVE);
   assign o_sync   = (w_cnt_x >= L_SYNC_LO) && (w_cnt_x < L_SYNC_HI);

   // Position counter: held at zero while cleared, wraps after TOTAL-1
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    r_cnt <= '0;
      else if (i_clr)  r_cnt <= '0;
      else if (i_adv)  r_cnt <= o_last ? '0 : r_cnt + W_CNT'(1);
   end

endmodule

// File: rtl/smoldvi_timing_ctrl.sv
// smoldvi video timing sequencer: raster generation, upstream pixel
// handshake, registered pixel/sync bundle for the TMDS encoders, and
// frame-boundary-only enable/disable with a sticky underrun flag.
module smoldvi_timing_ctrl
   import smoldvi_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
   parameter int unsigned H_FP       = DEF_H_FP,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BP       = DEF_H_BP,
   parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
   parameter int unsigned V_FP       = DEF_V_FP,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BP       = DEF_V_BP,
   parameter logic        H_SYNC_POL = DEF_H_SYNC_POL,
   parameter logic        V_SYNC_POL = DEF_V_SYNC_POL,
   parameter int unsigned W_CNT      = DEF_W_CNT
) (
   input  logic             clk_pix,
   input  logic             rst_n_pix,
   input  logic             en,
   input  logic             clr_underrun,
   input  logic             pix_valid,
   input  logic [PIX_W-1:0] pix_rgb,
   output logic             pix_rdy,
   output logic             den,
   output logic             hsync,
   output logic             vsync,
   output logic [PIX_W-1:0] rgb,
   output logic             frame_start,
   output logic             underrun,
   output logic             running
);

   state_t           r_state;
   tmds_out_t        r_out;
   logic             r_underrun;

   logic             w_run;
   logic [W_CNT-1:0] w_h_cnt, w_v_cnt;
   logic             w_h_last, w_v_last;
   logic             w_h_act, w_v_act;
   logic             w_h_sync, w_v_sync;
   logic             w_active;
   logic             w_frame_top;

   assign w_run = (r_state == ST_RUN);

   smoldvi_timing_axis #(
      .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .W_CNT (W_CNT)
   ) u_h_axis (
      .i_clk    (clk_pix),
      .i_rst_n  (rst_n_pix),
      .i_clr    (~w_run),
      .i_adv    (w_run),
      .o_cnt    (w_h_cnt),
      .o_last   (w_h_last),
      .o_active (w_h_act),
      .o_sync   (w_h_sync)
   );

   smoldvi_timing_axis #(
      .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .W_CNT (W_CNT)
   ) u_v_axis (
      .i_clk    (clk_pix),
      .i_rst_n  (rst_n_pix),
      .i_clr    (~w_run),
      .i_adv    (w_run & w_h_last),
      .o_cnt    (w_v_cnt),
      .o_last   (w_v_last),
      .o_active (w_v_act),
      .o_sync   (w_v_sync)
   );

   assign w_active    = w_run & w_h_act & w_v_act;
   assign w_frame_top = w_run & (w_h_cnt == '0) & (w_v_cnt == '0);

   // Pixels are only taken inside the visible area
   assign pix_rdy = w_active;

   // Start on en from idle; stop only on the very last cycle of a frame
   always_ff @(posedge clk_pix or negedge rst_n_pix) begin
      if (!rst_n_pix) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (en) r_state <= ST_RUN;
            ST_RUN:  if (w_h_last && w_v_last && !en) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // One-cycle registered decode so pixel, den and syncs leave together
   always_ff @(posedge clk_pix or negedge rst_n_pix) begin
      if (!rst_n_pix) begin
         r_out <= '{den: 1'b0, hsync: ~H_SYNC_POL, vsync: ~V_SYNC_POL,
                    frame_start: 1'b0, rgb: '0};
      end else begin
         r_out.den         <= w_active;
         r_out.rgb         <= (w_active && pix_valid) ? pix_rgb : '0;
         r_out.hsync       <= sync_level(w_run & w_h_sync, H_SYNC_POL);
         r_out.vsync       <= sync_level(w_run & w_v_sync, V_SYNC_POL);
         r_out.frame_start <= w_frame_top;
      end
   end

   // Sticky starvation flag; a new starvation beats a simultaneous clear
   always_ff @(posedge clk_pix or negedge rst_n_pix) begin
      if (!rst_n_pix)                r_underrun <= 1'b0;
      else if (w_active && !pix_valid) r_underrun <= 1'b1;
      else if (clr_underrun)         r_underrun <= 1'b0;
   end

   assign den         = r_out.den;
   assign hsync       = r_out.hsync;
   assign vsync       = r_out.vsync;
   assign rgb         = r_out.rgb;
   assign frame_start = r_out.frame_start;
   assign underrun    = r_underrun;
   assign running     = w_run;

endmodule

// File: tb/tb_smoldvi_timing_ctrl.sv
// Directed bench for smoldvi_timing_ctrl on a tiny 8x6 raster
// (H 4/1/2/1, V 3/1/1/1, both syncs active low).
module tb_smoldvi_timing_ctrl;

   logic        clk_pix = 1'b0;
   logic        rst_n_pix;
   logic        en, clr_underrun, pix_valid;
   logic [23:0] pix_rgb;
   logic        pix_rdy, den, hsync, vsync, frame_start, underrun, running;
   logic [23:0] rgb;

   int errors = 0;
   int checks = 0;

   // reference raster state
   bit m_run;
   int m_h, m_v;
   bit m_ur;
   int px;

   smoldvi_timing_ctrl #(
      .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .H_SYNC_POL (1'b0), .V_SYNC_POL (1'b0), .W_CNT (12)
   ) dut (
      .clk_pix      (clk_pix),
      .rst_n_pix    (rst_n_pix),
      .en           (en),
      .clr_underrun (clr_underrun),
      .pix_valid    (pix_valid),
      .pix_rgb      (pix_rgb),
      .pix_rdy      (pix_rdy),
      .den          (den),
      .hsync        (hsync),
      .vsync        (vsync),
      .rgb          (rgb),
      .frame_start  (frame_start),
      .underrun     (underrun),
      .running      (running)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_den"},     den,         32'd0);
      chk({pfx, "_hsync"},   hsync,       32'd1);
      chk({pfx, "_vsync"},   vsync,       32'd1);
      chk({pfx, "_rgb"},     rgb,         32'd0);
      chk({pfx, "_fs"},      frame_start, 32'd0);
      chk({pfx, "_ur"},      underrun,    32'd0);
      chk({pfx, "_running"}, running,     32'd0);
      chk({pfx, "_pix_rdy"}, pix_rdy,     32'd0);
   endtask

   // One clock: check pix_rdy for the current cycle, predict the registered
   // outputs from the current raster position, advance, then compare.
   task automatic step();
      bit          act, xfer;
      bit          e_den, e_hs, e_vs, e_fs;
      logic [23:0] e_rgb;
      act = m_run && (m_h < 4) && (m_v < 3);
      chk("pix_rdy", pix_rdy, 32'(act));
      e_den = act;
      e_rgb = (act && pix_valid) ? pix_rgb : 24'd0;
      e_hs  = !(m_run && (m_h == 5 || m_h == 6));
      e_vs  = !(m_run && (m_v == 4));
      e_fs  = m_run && (m_h == 0) && (m_v == 0);
      if (act && !pix_valid) m_ur = 1'b1;
      else if (clr_underrun)  m_ur = 1'b0;
      xfer = act && pix_valid;
      if (!m_run) begin
         if (en) m_run = 1'b1;
      end else if (m_h == 7) begin
         m_h = 0;
         if (m_v == 5) begin
            m_v = 0;
            if (!en) m_run = 1'b0;
         end else begin
            m_v++;
         end
      end else begin
         m_h++;
      end
      @(posedge clk_pix); #2;
      chk("den",         den,         32'(e_den));
      chk("rgb",         rgb,         32'(e_rgb));
      chk("hsync",       hsync,       32'(e_hs));
      chk("vsync",       vsync,       32'(e_vs));
      chk("frame_start", frame_start, 32'(e_fs));
      chk("underrun",    underrun,    32'(m_ur));
      chk("running",     running,     32'(m_run));
      if (xfer) begin
         px++;
         pix_rgb = 24'(px);
      end
   endtask

   initial begin
      rst_n_pix = 1'b0; en = 1'b0; clr_underrun = 1'b0; pix_valid = 1'b0; pix_rgb = '0;
      m_run = 1'b0; m_h = 0; m_v = 0; m_ur = 1'b0; px = 0;

      // reset state
      repeat (3) @(posedge clk_pix);
      #2;
      chk_reset_vals("rst");
      rst_n_pix = 1'b1;

      // frame 1: continuous pixels except one starved slot at line 1 pixel 2
      en = 1'b1; pix_valid = 1'b1; pix_rgb = 24'(px);
      step();
      repeat (48) begin
         pix_valid = !(m_v == 1 && m_h == 2);
         step();
      end
      chk("ur_sticky_frame1", underrun, 32'd1);
      chk("px_after_frame1", rgb, 32'd0);

      // frame 2: clear at first pixel, then clear+starve together at
      // cycle 10 where en is also dropped
      repeat (48) begin
         clr_underrun = (m_v == 0 && m_h == 0) || (m_v == 1 && m_h == 2);
         pix_valid    = !(m_v == 1 && m_h == 2);
         if (m_v == 1 && m_h == 2) en = 1'b0;
         step();
      end
      clr_underrun = 1'b0;
      chk("stopped_after_frame", running, 32'd0);
      chk("ur_set_beats_clr", underrun, 32'd1);

      // idle: nothing moves
      repeat (6) step();
      clr_underrun = 1'b1;
      step();
      clr_underrun = 1'b0;
      chk("ur_cleared_idle", underrun, 32'd0);

      // restart: frame_start on the second edge after en
      en = 1'b1;
      step();
      chk("fs_first_edge", frame_start, 32'd0);
      step();
      chk("fs_second_edge", frame_start, 32'd1);
      repeat (2) step();
      chk("mid_line_den", den, 32'd1);

      // asynchronous reset mid active line
      rst_n_pix = 1'b0;
      #1;
      chk_reset_vals("async");
      m_run = 1'b0; m_h = 0; m_v = 0; m_ur = 1'b0;
      @(posedge clk_pix); #2;
      chk_reset_vals("held");
      rst_n_pix = 1'b1;

      // clean frame after reset, pixels offered through blanking too
      pix_valid = 1'b1;
      repeat (56) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
